// File: rtl/sprite_image_loader.sv
// Sprite image loader: accepts a valid/ready stream of palette indices and writes
// WIDTH*HEIGHT entries into a sprite image RAM in raster order, flagging illegal indices.
module sprite_image_loader #(
    parameter int WIDTH         = 100,
    parameter int HEIGHT        = 100,
    parameter int PALETTE_DEPTH = 100,
    parameter int ADDR_W        = $clog2(WIDTH*HEIGHT)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [7:0]        data_in,
    input  logic              data_valid_in,
    output logic              data_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [7:0]        wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              bad_index_out
);

    localparam int                PIXELS    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    // Palette limit widened to 9 bits so a depth of 256 or more accepts every byte.
    localparam logic [8:0]        PAL_LIMIT = (PALETTE_DEPTH > 255) ? 9'd256 : 9'(PALETTE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_done;
    logic              r_bad;

    logic              w_ready;
    logic              w_accept;
    logic              w_clear;
    logic              w_legal;
    logic              w_last;

    assign w_legal = ({1'b0, data_in} < PAL_LIMIT);
    assign w_last  = (r_count == LAST_ADDR);

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Abort takes priority over a simultaneous start.
                if (start_in && !abort_in) begin
                    w_state_next = ST_LOAD;
                    w_clear      = 1'b1;
                end
            end
            ST_LOAD: begin
                w_ready  = !abort_in;
                w_accept = data_valid_in && !abort_in;
                if (abort_in) begin
                    w_state_next = ST_IDLE;
                end else if (w_accept && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            r_done  <= (r_state == ST_DONE) && !abort_in;
            if (w_accept) begin
                r_wr_addr <= r_count;
                r_wr_data <= w_legal ? data_in : 8'd0;
                if (!w_legal) begin
                    r_bad <= 1'b1;
                end
                // Counter saturates on the final pixel so a load never wraps to address 0.
                if (!w_last) begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_clear) begin
                r_count <= '0;
                r_bad   <= 1'b0;
            end
        end
    end

    assign data_ready_out = w_ready;
    assign wr_en_out      = r_wr_en;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign busy_out       = (r_state != ST_IDLE);
    assign done_out       = r_done;
    assign bad_index_out  = r_bad;

endmodule

// File: tb/tb_sprite_image_loader.sv
// Directed bench for sprite_image_loader on a 4x2 image with palette depth 100.
module tb_sprite_image_loader;

    localparam int ADDR_W = 3;

    logic              pixel_clk_in = 1'b0;
    logic              rst_n_in     = 1'b1;
    logic              start_in     = 1'b0;
    logic              abort_in     = 1'b0;
    logic [7:0]        data_in      = 8'd0;
    logic              data_valid_in = 1'b0;
    logic              data_ready_out;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [7:0]        wr_data_out;
    logic              busy_out;
    logic              done_out;
    logic              bad_index_out;

    int n_vec      = 0;
    int n_bad      = 0;
    int wr_total   = 0;
    int done_total = 0;
    int wr_mark;
    int done_mark;

    sprite_image_loader #(
        .WIDTH         (4),
        .HEIGHT        (2),
        .PALETTE_DEPTH (100)
    ) dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .abort_in       (abort_in),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .data_ready_out (data_ready_out),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .bad_index_out  (bad_index_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    always @(negedge pixel_clk_in) begin
        if (wr_en_out) begin
            wr_total = wr_total + 1;
            $display("write addr=%0d data=%0d bad=%0d", wr_addr_out, wr_data_out, bad_index_out);
        end
        if (done_out) begin
            done_total = done_total + 1;
            $display("done pulse at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixel_clk_in);
        #1;
    endtask

    task automatic start_load();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("start_busy", 32'(busy_out), 1);
        check("start_bad_clear", 32'(bad_index_out), 0);
    endtask

    task automatic beat(input logic [7:0] d, input int exp_addr, input int exp_data);
        data_in       = d;
        data_valid_in = 1'b1;
        #1;
        check("beat_ready", 32'(data_ready_out), 1);
        tick();
        check("beat_wr_en", 32'(wr_en_out), 1);
        check("beat_addr", 32'(wr_addr_out), 32'(exp_addr));
        check("beat_data", 32'(wr_data_out), 32'(exp_data));
        check("beat_no_done", 32'(done_out), 0);
    endtask

    task automatic finish_load();
        data_valid_in = 1'b0;
        #1;
        check("done_st_ready", 32'(data_ready_out), 0);
        check("done_st_busy", 32'(busy_out), 1);
        check("done_st_pulse", 32'(done_out), 0);
        tick();
        check("done_pulse", 32'(done_out), 1);
        check("done_busy_low", 32'(busy_out), 0);
        check("done_wr_idle", 32'(wr_en_out), 0);
    endtask

    initial begin
        logic [7:0] ill_in  [8];
        logic [7:0] ill_exp [8];
        ill_in  = '{8'd10, 8'd20, 8'd30, 8'd120, 8'd40, 8'd50, 8'd60, 8'd70};
        ill_exp = '{8'd10, 8'd20, 8'd30, 8'd0,   8'd40, 8'd50, 8'd60, 8'd70};

        // Power-on reset: outputs clear asynchronously, before any clock edge.
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en_out), 0);
        check("rst_addr", 32'(wr_addr_out), 0);
        check("rst_data", 32'(wr_data_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_done", 32'(done_out), 0);
        check("rst_bad", 32'(bad_index_out), 0);
        check("rst_ready", 32'(data_ready_out), 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        check("idle_ready", 32'(data_ready_out), 0);
        check("idle_busy", 32'(busy_out), 0);

        // Full load, continuous valid.
        wr_mark = wr_total; done_mark = done_total;
        start_load();
        for (int i = 0; i < 8; i++) begin
            beat(8'(i), i, i);
        end
        finish_load();
        tick();
        check("full_done_zero", 32'(done_out), 0);
        check("full_writes", 32'(wr_total - wr_mark), 8);
        check("full_dones", 32'(done_total - done_mark), 1);

        // Throttled source: valid on even cycles only.
        wr_mark = wr_total; done_mark = done_total;
        start_load();
        for (int i = 0; i < 15; i++) begin
            if ((i % 2) == 0) begin
                beat(8'(i / 2), i / 2, i / 2);
            end else begin
                data_valid_in = 1'b0;
                data_in       = 8'hEE;
                #1;
                check("thr_ready", 32'(data_ready_out), 1);
                tick();
                check("thr_no_wr", 32'(wr_en_out), 0);
                check("thr_addr_hold", 32'(wr_addr_out), 32'(i / 2));
                check("thr_data_hold", 32'(wr_data_out), 32'(i / 2));
            end
        end
        finish_load();
        tick();
        check("thr_writes", 32'(wr_total - wr_mark), 8);
        check("thr_dones", 32'(done_total - done_mark), 1);

        // Illegal palette index at beat 3.
        start_load();
        for (int i = 0; i < 8; i++) begin
            beat(ill_in[i], i, 32'(ill_exp[i]));
            check("ill_bad_flag", 32'(bad_index_out), (i >= 3) ? 1 : 0);
        end
        finish_load();
        check("ill_bad_after_done", 32'(bad_index_out), 1);
        tick();
        tick();
        check("ill_bad_sticky_idle", 32'(bad_index_out), 1);

        // Abort after 3 beats; next start clears the bad flag.
        done_mark = done_total;
        start_load();
        beat(8'd5, 0, 5);
        beat(8'd6, 1, 6);
        beat(8'd7, 2, 7);
        abort_in      = 1'b1;
        data_in       = 8'd9;
        data_valid_in = 1'b1;
        #1;
        check("abort_ready", 32'(data_ready_out), 0);
        tick();
        check("abort_no_wr", 32'(wr_en_out), 0);
        check("abort_busy", 32'(busy_out), 0);
        check("abort_no_done", 32'(done_out), 0);
        abort_in = 1'b0;
        #1;
        check("abort_idle_ready", 32'(data_ready_out), 0);
        start_in = 1'b1;
        abort_in = 1'b1;
        tick();
        start_in = 1'b0;
        abort_in = 1'b0;
        check("start_abort_idle", 32'(busy_out), 0);
        start_load();
        beat(8'd33, 0, 33);
        abort_in      = 1'b1;
        data_valid_in = 1'b0;
        tick();
        abort_in = 1'b0;
        check("abort2_busy", 32'(busy_out), 0);
        tick();
        check("abort_dones", 32'(done_total - done_mark), 0);

        // Overrun: ninth byte and a start during DONE are both ignored.
        wr_mark = wr_total; done_mark = done_total;
        start_load();
        for (int i = 0; i < 8; i++) begin
            beat(8'(64 + i), i, 64 + i);
        end
        data_in       = 8'd72;
        data_valid_in = 1'b1;
        start_in      = 1'b1;
        #1;
        check("ovr_ready", 32'(data_ready_out), 0);
        check("ovr_busy", 32'(busy_out), 1);
        tick();
        start_in = 1'b0;
        check("ovr_done", 32'(done_out), 1);
        check("ovr_no_wr", 32'(wr_en_out), 0);
        check("ovr_busy_low", 32'(busy_out), 0);
        #1;
        check("ovr_idle_ready", 32'(data_ready_out), 0);
        tick();
        check("ovr_start_ignored", 32'(busy_out), 0);
        check("ovr_no_wr2", 32'(wr_en_out), 0);
        data_valid_in = 1'b0;
        check("ovr_writes", 32'(wr_total - wr_mark), 8);
        check("ovr_dones", 32'(done_total - done_mark), 1);

        // Reset mid-load: outputs clear immediately, no done pulse follows.
        done_mark = done_total;
        start_load();
        beat(8'd200, 0, 0);
        check("mid_bad_set", 32'(bad_index_out), 1);
        beat(8'd3, 1, 3);
        #2 rst_n_in = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en_out), 0);
        check("mid_rst_addr", 32'(wr_addr_out), 0);
        check("mid_rst_data", 32'(wr_data_out), 0);
        check("mid_rst_busy", 32'(busy_out), 0);
        check("mid_rst_bad", 32'(bad_index_out), 0);
        check("mid_rst_ready", 32'(data_ready_out), 0);
        #10 rst_n_in = 1'b1;
        tick();
        #1;
        check("mid_post_ready", 32'(data_ready_out), 0);
        check("mid_post_busy", 32'(busy_out), 0);
        tick();
        tick();
        check("mid_no_done", 32'(done_total - done_mark), 0);
        data_valid_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sprite_image_loader.md
Name: sprite_image_loader

Overview:
- Writer side of the sprite image BROM path.
- Accepts a byte stream of palette indices over a valid/ready handshake and writes WIDTH*HEIGHT entries into the write port of a sprite image RAM, in raster order starting at address 0.
- Sits between the host/UART byte source and the sprite image RAM, so sprite bitmaps can be replaced at run time.
- Reports completion with a done pulse and flags palette indices that are out of range.

Parameters:
- WIDTH, 100, sprite width in pixels.
- HEIGHT, 100, sprite height in pixels.
- PALETTE_DEPTH, 100, number of valid palette entries; indices >= this are illegal.
- ADDR_W, $clog2(WIDTH*HEIGHT), RAM address width (derived).

Ports:
- pixel_clk_in  input  1  single clock; all logic on rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- start_in  input  1  one-cycle request to begin loading a new image.
- abort_in  input  1  cancel the current load.
- data_in  input  8  palette index byte.
- data_valid_in  input  1  data_in valid.
- data_ready_out  output  1  loader can accept a byte this cycle.
- wr_en_out  output  1  RAM write strobe.
- wr_addr_out  output  ADDR_W  RAM write address.
- wr_data_out  output  8  RAM write data.
- busy_out  output  1  high in LOAD and DONE.
- done_out  output  1  one-cycle pulse when a full image has been written.
- bad_index_out  output  1  sticky flag: an illegal palette index was received during the current or last load.

Behaviour:
- Reset: clock is pixel_clk_in; reset is rst_n_in, asynchronous, active-low. While rst_n_in=0:
  - state=IDLE, pixel counter=0.
  - wr_en_out=0, wr_addr_out=0, wr_data_out=0.
  - done_out=0, bad_index_out=0, busy_out=0, data_ready_out=0.
- Reset applied mid-load drops the load with no done pulse. RAM contents are not affected beyond writes already issued.
- States: IDLE, LOAD, DONE.
- IDLE:
  - data_ready_out=0.
  - start_in=1 -> LOAD next cycle; counter cleared to 0; bad_index_out cleared.
- LOAD:
  - data_ready_out = !abort_in (combinational).
  - A beat is accepted when data_valid_in && data_ready_out.
  - start_in is ignored in LOAD.
- Accepted beat in cycle N produces a write in cycle N+1:
  - wr_en_out=1, wr_addr_out=counter value at N.
  - wr_data_out = data_in if data_in < PALETTE_DEPTH; otherwise wr_data_out=0 and bad_index_out set at N+1.
  - Counter increments at the end of cycle N.
- Cycles with no accepted beat: wr_en_out=0. Address and data hold their last values.
- Back-to-back beats are permitted every cycle, giving full throughput.
- Last beat (counter = WIDTH*HEIGHT-1) accepted at cycle N:
  - state -> DONE at N+1; the final write strobe occurs at N+1.
  - data_ready_out=0 from N+1.
  - DONE lasts exactly one cycle: done_out=1 at N+2, state=IDLE at N+2, busy_out=0 at N+2.
- The counter never exceeds WIDTH*HEIGHT-1. There is no wrap-around write to address 0 within a load.
- Extra bytes presented after the last beat are not accepted, because ready=0.
- abort_in:
  - In LOAD or DONE, abort_in=1 -> IDLE next cycle with no done_out.
  - No beat is accepted in the abort cycle.
  - A write already registered from the previous cycle's beat still appears that cycle.
- abort_in and start_in asserted together in IDLE: abort wins and the state stays IDLE.
- start_in in DONE is ignored.
- bad_index_out holds its value through IDLE until the next accepted start_in.

Test Plan:
- Reset: hold rst_n_in=0 mid-stream -> all outputs 0 immediately (asynchronous). Release -> IDLE, data_ready_out=0.
- Full load, WIDTH=4, HEIGHT=2, bytes 0..7 with continuous valid:
  - 8 consecutive wr_en_out pulses with addr 0..7 and data 0..7, each one cycle after acceptance.
  - done_out pulses once, one cycle after the addr-7 write.
  - busy_out falls with done_out.
- Throttled source: valid toggling 1/0 -> writes only in cycles following accepted beats. Addresses remain contiguous 0..7; done_out still fires once.
- Illegal index: byte 120 at beat 3 with PALETTE_DEPTH=100 -> write addr 3 with data 0, bad_index_out=1 and sticky after done. Next start_in clears it.
- Abort after 3 beats -> no done_out, ready low next cycle. A new start then writes from addr 0.
- Overrun: 9 bytes presented for an 8-pixel image -> 9th byte never accepted, exactly 8 writes; start_in during DONE ignored.
